demux12_stream: RTL
===================

// Module: demux12_stream
// PURPOSE
//  Registered 1-to-N demultiplexer: the dispatch counterpart of the mux21 select path.
//  Accepts one data word per handshake on a single input.
//  Routes it by a per-word select to one of N_OUT outputs.
//  Each output has a one-entry holding register, so a stalled output never corrupts
//  the other outputs.
//  Sits between a single producer and N independent consumers in the datapath.
// PARAMETERS
//  WIDTH   8  data word width in bits
//  N_OUT   2  number of outputs; legal range 2..16
//  SEL_W   $clog2(N_OUT)  select width; derived, never overridden
// PORTS
//  clk        in   1              rising-edge clock; the only clock
//  rst_n      in   1              asynchronous, active-low reset
//  in_valid   in   1              input word present
//  in_ready   out  1              block can take input word this cycle
//  in_data    in   WIDTH          input word
//  in_sel     in   SEL_W          destination index; sampled with in_data
//  out_valid  out  N_OUT          per-output word present
//  out_ready  in   N_OUT          per-output consumer accepts word
//  out_data   out  N_OUT*WIDTH    per-output word; slice i = [i*WIDTH +: WIDTH]
//  drop_cnt   out  8              count of words dropped for out-of-range in_sel; saturating
// BEHAVIOUR
//  Reset (rst_n low, takes effect immediately, no clock needed):
//   - out_valid = 0, out_data = 0, drop_cnt = 0, all holding registers empty.
//   - Reset mid-operation discards held words; no partial transfer completes.
//  Handshake:
//   - A transfer occurs on a rising edge where valid && ready.
//   - in_ready is combinational and is valid for in-range in_sel only:
//     in_ready = !out_valid[in_sel] | out_ready[in_sel].
//   - in_ready never depends on in_valid.
//  Accept: on an input transfer with in_sel < N_OUT, slot in_sel loads in_data.
//   out_valid[in_sel] is 1 on the following cycle (latency = 1 clock).
//  Hold:
//   - While out_valid[i] && !out_ready[i], out_data slice i and out_valid[i] stay stable.
//   - Other slots are unaffected.
//  Drain: on out_valid[i] && out_ready[i] with no refill of slot i, out_valid[i] goes 0 next cycle.
//  Simultaneous drain + refill of the same slot in one cycle:
//   - The slot loads the new word and out_valid stays 1. No bubble, no loss.
//  Out-of-range select (in_sel >= N_OUT, only possible when N_OUT is not a power of 2):
//   - in_ready = 1 and the word is discarded.
//   - drop_cnt increments by 1, saturating at 255.
//  Unselected slots ignore in_data and in_valid entirely.
//  Throughput: one word per clock when the targeted consumer keeps out_ready high.
// STRUCTURE
//  demux_pkg:
//   - function sel_width(n) returning $clog2(n), with minimum 1.
//   - localparam DROP_CNT_W = 8.
//  Sub-module demux_slot, instantiated N_OUT times with a generate loop.
//   - One-entry valid/data register with load, drain and async reset.
//   - Ports: clk, rst_n, load, data_in, valid, ready, data_out.
//  Top level: select decode, in_ready mux, drop counter.
// TESTING
//  - Reset: rst_n = 0 asserted mid-cycle with slot 1 full -> out_valid = 2'b00 and out_data = 0 immediately; drop_cnt = 0.
//  - Basic route: in_data = 8'hA5, in_sel = 1, all ready -> next cycle out_valid = 2'b10, slice 1 = 8'hA5; slice 0 unchanged.
//  - Backpressure isolation: slot 0 full with out_ready[0] = 0; send 8'h3C to sel = 0 -> in_ready = 0.
//    Send 8'h77 to sel = 1 -> accepted, out_valid = 2'b11, slice 0 still holds the old word.
//  - Drain+refill: out_ready[0] = 1 with slot 0 full, new word 8'h11 to sel = 0 same cycle -> out_valid[0] stays 1 and slice 0 = 8'h11.
//    Back-to-back stream 0x00..0x0F arrives in order with no gaps.
//  - Out-of-range: N_OUT = 3, in_sel = 3 for 300 words -> in_ready = 1 throughout, no out_valid change, drop_cnt = 255.
//  - Random: 10k cycles with random in_valid/in_sel/out_ready -> scoreboard matches every word per output, in order, with no loss or duplication.
//    The bench calls $finish on the first mismatch and prints a completion message otherwise.

Source files
------------

// File: rtl/demux12_stream_pkg.sv
// Shared constants and helpers for the demux12_stream block and its interface.
package demux_pkg;

    localparam int DROP_CNT_W = 8;

    // Select width for n outputs; a 1-bit select is kept even for degenerate n.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux12_stream_if.sv
// Producer/consumer bundle of the 1-to-N stream demux; slave is the demux side.
interface demux12_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2
);
    localparam int SEL_W = demux_pkg::sel_width(N_OUT);

    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH-1:0]                    in_data;
    logic [SEL_W-1:0]                    in_sel;
    logic [N_OUT-1:0]                    out_valid;
    logic [N_OUT-1:0]                    out_ready;
    logic [N_OUT-1:0][WIDTH-1:0]         out_data;
    logic [demux_pkg::DROP_CNT_W-1:0]    drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );

endinterface

// File: rtl/demux12_stream_slot.sv
// One-entry output holding register: load wins over drain so a full slot can
// be drained and refilled in the same cycle without a bubble.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            data_out <= data_in;
        end else if (ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/demux12_stream.sv
// Registered 1-to-N stream demux: select decode, per-output holding slots and
// a saturating counter of words discarded for an out-of-range select.
module demux12_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    demux12_stream_if.slave  bus
);

    localparam int SEL_W = sel_width(N_OUT);

    logic                  in_range;
    logic                  take;
    logic [N_OUT-1:0]      load;
    logic [DROP_CNT_W-1:0] drop_q;

    // Ready looks only at the addressed slot, so one stalled consumer never
    // blocks traffic headed elsewhere; stray selects are always sunk.
    always_comb begin
        in_range     = ({1'b0, bus.in_sel} < (SEL_W+1)'(N_OUT));
        bus.in_ready = 1'b1;
        if (in_range)
            bus.in_ready = !bus.out_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
        take         = bus.in_valid & bus.in_ready;
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        assign load[i] = take & in_range & (bus.in_sel == SEL_W'(i));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .data_in  (bus.in_data),
            .valid    (bus.out_valid[i]),
            .ready    (bus.out_ready[i]),
            .data_out (bus.out_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= '0;
        else if (take && !in_range && drop_q != '1)
            drop_q <= drop_q + 1'b1;
    end

    assign bus.drop_cnt = drop_q;

endmodule
